// File: rtl/event_ack_nack_decoder.sv
// Decodes the memclk-domain ack/nack stream into readout allow credits, a validated
// nack FIFO for the readout generator and an ack address broadcast.
module event_ack_nack_decoder #(
    parameter int unsigned INIT_ALLOW = 8,
    parameter int unsigned NACK_DEPTH = 16,
    parameter logic [18:0] BTT        = 19'd459008
) (
    input  logic                          memclk,
    input  logic                          aresetn,
    input  logic [47:0]                   s_ack_tdata,
    input  logic                          s_ack_tvalid,
    output logic                          s_ack_tready,
    output logic [47:0]                   m_nack_tdata,
    output logic                          m_nack_tvalid,
    input  logic                          m_nack_tready,
    output logic [11:0]                   m_ack_tdata,
    output logic                          m_ack_tvalid,
    input  logic                          m_ack_tready,
    output logic                          allow_o,
    output logic                          init_done_o,
    output logic [15:0]                   nack_drop_count_o,
    output logic [$clog2(NACK_DEPTH):0]   nack_count_o
);

    localparam int unsigned PtrW = $clog2(NACK_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic {StInit, StRun} state_e;

    state_e            state_q;
    logic [7:0]        init_cnt_q;
    logic              allow_q;
    logic              ack_valid_q;
    logic [11:0]       ack_data_q;
    logic [PtrW-1:0]   wptr_q, rptr_q;
    logic [CntW-1:0]   count_q, count_d;
    logic [15:0]       drop_q;
    logic [47:0]       mem_q [NACK_DEPTH];

    logic              accept, is_nack, is_full_evt, nack_ok, push, pop, drop, fifo_full;
    logic [18:0]       offset;
    logic [10:0]       len;
    logic [19:0]       end_sum;
    logic [47:0]       push_data;

    assign offset      = s_ack_tdata[18:0];
    assign len         = s_ack_tdata[42:32];
    assign is_nack     = s_ack_tdata[45];
    assign is_full_evt = s_ack_tdata[46];

    // 20-bit sum: 19-bit offset plus a 14-bit byte length cannot overflow.
    assign end_sum = {1'b0, offset} + {6'd0, len, 3'd0};
    assign nack_ok = is_full_evt ||
                     ((len != 11'd0) && (offset[2:0] == 3'd0) && (end_sum <= {1'b0, BTT}));

    assign push_data = {1'b0, s_ack_tdata[46:43], is_full_evt ? 11'd0 : len,
                        s_ack_tdata[31:19], is_full_evt ? 19'd0 : offset};

    assign fifo_full    = (count_q == CntW'(NACK_DEPTH));
    assign s_ack_tready = (state_q == StRun) && !fifo_full && !(ack_valid_q && !m_ack_tready);
    assign accept       = s_ack_tvalid && s_ack_tready;
    assign push         = accept && is_nack && nack_ok;
    assign drop         = accept && is_nack && !nack_ok;
    assign pop          = m_nack_tvalid && m_nack_tready;

    always_ff @(posedge memclk) begin
        if (!aresetn) begin
            state_q    <= StInit;
            init_cnt_q <= 8'd0;
            allow_q    <= 1'b0;
        end else begin
            case (state_q)
                StInit: begin
                    if (init_cnt_q == 8'(INIT_ALLOW)) begin
                        state_q <= StRun;
                        allow_q <= 1'b0;
                    end else begin
                        allow_q    <= 1'b1;
                        init_cnt_q <= init_cnt_q + 8'd1;
                    end
                end
                StRun: allow_q <= accept && s_ack_tdata[47];
                default: state_q <= StInit;
            endcase
        end
    end

    // A consume and a fresh load in the same cycle keep the ack valid with new data.
    always_ff @(posedge memclk) begin
        if (!aresetn) begin
            ack_valid_q <= 1'b0;
            ack_data_q  <= 12'd0;
        end else if (accept && !is_nack) begin
            ack_valid_q <= 1'b1;
            ack_data_q  <= s_ack_tdata[31:20];
        end else if (m_ack_tready) begin
            ack_valid_q <= 1'b0;
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge memclk) begin
        if (!aresetn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            drop_q  <= 16'd0;
        end else begin
            count_q <= count_d;
            if (push) wptr_q <= wptr_q + PtrW'(1);
            if (pop) rptr_q <= rptr_q + PtrW'(1);
            if (drop && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
        end
    end

    always_ff @(posedge memclk) begin
        if (push) mem_q[wptr_q] <= push_data;
    end

    assign m_nack_tdata      = mem_q[rptr_q];
    assign m_nack_tvalid     = (count_q != '0);
    assign m_ack_tdata       = ack_data_q;
    assign m_ack_tvalid      = ack_valid_q;
    assign allow_o           = allow_q;
    assign init_done_o       = (state_q == StRun);
    assign nack_drop_count_o = drop_q;
    assign nack_count_o      = count_q;

endmodule

// File: tb/tb_event_ack_nack_decoder.sv
// Directed bench for event_ack_nack_decoder: init credits, ack path, nack validation,
// FIFO fill/wrap and mid-operation reset.
module tb_event_ack_nack_decoder;

    logic        memclk = 1'b0;
    logic        aresetn;
    logic [47:0] s_ack_tdata;
    logic        s_ack_tvalid;
    logic        s_ack_tready;
    logic [47:0] m_nack_tdata;
    logic        m_nack_tvalid;
    logic        m_nack_tready;
    logic [11:0] m_ack_tdata;
    logic        m_ack_tvalid;
    logic        m_ack_tready;
    logic        allow_o;
    logic        init_done_o;
    logic [15:0] nack_drop_count_o;
    logic [4:0]  nack_count_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 memclk = ~memclk;

    event_ack_nack_decoder #(
        .INIT_ALLOW (8),
        .NACK_DEPTH (16),
        .BTT        (19'd459008)
    ) dut (
        .memclk            (memclk),
        .aresetn           (aresetn),
        .s_ack_tdata       (s_ack_tdata),
        .s_ack_tvalid      (s_ack_tvalid),
        .s_ack_tready      (s_ack_tready),
        .m_nack_tdata      (m_nack_tdata),
        .m_nack_tvalid     (m_nack_tvalid),
        .m_nack_tready     (m_nack_tready),
        .m_ack_tdata       (m_ack_tdata),
        .m_ack_tvalid      (m_ack_tvalid),
        .m_ack_tready      (m_ack_tready),
        .allow_o           (allow_o),
        .init_done_o       (init_done_o),
        .nack_drop_count_o (nack_drop_count_o),
        .nack_count_o      (nack_count_o)
    );

    function automatic logic [47:0] mk(input logic al, input logic fe, input logic nk,
                                       input logic [10:0] len, input logic [11:0] up,
                                       input logic [18:0] off);
        return {al, fe, nk, 2'b00, len, up, 1'b0, off};
    endfunction

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge memclk);
        #1;
    endtask

    task automatic send(input logic [47:0] w);
        s_ack_tdata  = w;
        s_ack_tvalid = 1'b1;
        tick();
        s_ack_tvalid = 1'b0;
        s_ack_tdata  = '0;
    endtask

    task automatic init_seq(input string tag);
        aresetn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk({tag, "_allow"}, 48'(allow_o), 48'd1);
            chk({tag, "_nodone"}, 48'(init_done_o), 48'd0);
            chk({tag, "_noready"}, 48'(s_ack_tready), 48'd0);
        end
        tick();
        chk({tag, "_allow_end"}, 48'(allow_o), 48'd0);
        chk({tag, "_done"}, 48'(init_done_o), 48'd1);
        chk({tag, "_ready"}, 48'(s_ack_tready), 48'd1);
        chk({tag, "_nvalid"}, 48'(m_nack_tvalid), 48'd0);
        chk({tag, "_avalid"}, 48'(m_ack_tvalid), 48'd0);
    endtask

    initial begin
        aresetn       = 1'b0;
        s_ack_tdata   = '0;
        s_ack_tvalid  = 1'b0;
        m_nack_tready = 1'b0;
        m_ack_tready  = 1'b0;
        tick();
        tick();
        chk("rst_allow", 48'(allow_o), 48'd0);
        chk("rst_done", 48'(init_done_o), 48'd0);
        chk("rst_ready", 48'(s_ack_tready), 48'd0);
        chk("rst_nvalid", 48'(m_nack_tvalid), 48'd0);
        chk("rst_avalid", 48'(m_ack_tvalid), 48'd0);
        chk("rst_cnt", 48'(nack_count_o), 48'd0);
        chk("rst_drop", 48'(nack_drop_count_o), 48'd0);

        init_seq("init");

        // Ack path with backpressure
        send(48'h8000_0ABC_0000);
        chk("ack1_valid", 48'(m_ack_tvalid), 48'd1);
        chk("ack1_data", 48'(m_ack_tdata), 48'h0AB);
        chk("ack1_allow", 48'(allow_o), 48'd1);
        chk("ack1_block", 48'(s_ack_tready), 48'd0);
        s_ack_tdata  = mk(0, 0, 0, 11'd0, 12'h0CD, 19'd0);
        s_ack_tvalid = 1'b1;
        tick();
        chk("ack2_block", 48'(s_ack_tready), 48'd0);
        chk("ack2_hold", 48'(m_ack_tdata), 48'h0AB);
        chk("ack2_noallow", 48'(allow_o), 48'd0);
        tick();
        chk("ack2_hold2", 48'(m_ack_tdata), 48'h0AB);
        m_ack_tready = 1'b1;
        #1;
        chk("ack2_ready", 48'(s_ack_tready), 48'd1);
        tick();
        s_ack_tvalid = 1'b0;
        chk("ack2_valid", 48'(m_ack_tvalid), 48'd1);
        chk("ack2_data", 48'(m_ack_tdata), 48'h0CD);
        tick();
        chk("ack2_consumed", 48'(m_ack_tvalid), 48'd0);

        // Nack validation
        send(mk(0, 0, 1, 11'd16, 12'h123, 19'h00100));
        chk("pn_valid", 48'(m_nack_tvalid), 48'd1);
        chk("pn_data", m_nack_tdata, {5'b00100, 11'd16, 12'h123, 1'b0, 19'h00100});
        chk("pn_cnt", 48'(nack_count_o), 48'd1);
        m_nack_tready = 1'b1;
        send(mk(1, 0, 1, 11'd17, 12'h000, 19'd458880));
        m_nack_tready = 1'b0;
        chk("ovf_drop", 48'(nack_drop_count_o), 48'd1);
        chk("ovf_cnt", 48'(nack_count_o), 48'd0);
        chk("ovf_allow", 48'(allow_o), 48'd1);
        send(mk(0, 0, 1, 11'd16, 12'h001, 19'd458880));
        chk("edge_cnt", 48'(nack_count_o), 48'd1);
        chk("edge_drop", 48'(nack_drop_count_o), 48'd1);
        send(mk(0, 1, 1, 11'd5, 12'h7FF, 19'h7FFFF));
        chk("fe_cnt", 48'(nack_count_o), 48'd2);
        chk("fe_head", m_nack_tdata, {5'b00100, 11'd16, 12'h001, 1'b0, 19'd458880});
        m_nack_tready = 1'b1;
        tick();
        chk("fe_data", m_nack_tdata, {5'b01100, 11'd0, 12'h7FF, 1'b0, 19'd0});
        tick();
        m_nack_tready = 1'b0;
        chk("fe_empty", 48'(m_nack_tvalid), 48'd0);
        send(mk(0, 0, 1, 11'd1, 12'h000, 19'h00004));
        chk("mis_drop", 48'(nack_drop_count_o), 48'd2);
        send(mk(0, 0, 1, 11'd0, 12'h000, 19'h00008));
        chk("len0_drop", 48'(nack_drop_count_o), 48'd3);
        chk("len0_cnt", 48'(nack_count_o), 48'd0);

        // Fill, pop, wrap
        for (int i = 0; i < 16; i++) send(mk(0, 0, 1, 11'(i + 1), 12'(i), 19'(i * 8)));
        chk("full_cnt", 48'(nack_count_o), 48'd16);
        chk("full_ready", 48'(s_ack_tready), 48'd0);
        m_nack_tready = 1'b1;
        tick();
        m_nack_tready = 1'b0;
        chk("pop_cnt", 48'(nack_count_o), 48'd15);
        chk("pop_ready", 48'(s_ack_tready), 48'd1);
        send(mk(0, 0, 1, 11'd17, 12'd16, 19'd128));
        m_nack_tready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            chk("drain_data", m_nack_tdata, mk(0, 0, 1, 11'(k + 1), 12'(k), 19'(k * 8)));
            tick();
        end
        m_nack_tready = 1'b0;
        chk("drain_empty", 48'(m_nack_tvalid), 48'd0);
        chk("drain_cnt", 48'(nack_count_o), 48'd0);

        // Mid-operation reset
        for (int i = 0; i < 5; i++) send(mk(0, 0, 1, 11'd1, 12'(i), 19'd0));
        m_ack_tready = 1'b0;
        send(mk(0, 0, 0, 11'd0, 12'h555, 19'd0));
        chk("pre_cnt", 48'(nack_count_o), 48'd5);
        chk("pre_ack", 48'(m_ack_tdata), 48'h555);
        chk("pre_avalid", 48'(m_ack_tvalid), 48'd1);
        aresetn = 1'b0;
        tick();
        chk("mr_nvalid", 48'(m_nack_tvalid), 48'd0);
        chk("mr_avalid", 48'(m_ack_tvalid), 48'd0);
        chk("mr_cnt", 48'(nack_count_o), 48'd0);
        chk("mr_drop", 48'(nack_drop_count_o), 48'd0);
        chk("mr_ready", 48'(s_ack_tready), 48'd0);
        chk("mr_done", 48'(init_done_o), 48'd0);
        m_ack_tready = 1'b1;
        init_seq("reinit");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
